// File: rtl/motion_bbox_tracker.sv
// Per-frame motion accumulator: counts changed pixels in raster order, tracks their
// bounding box, and publishes count, box and a thresholded motion flag at end of frame.
`timescale 1ns/1ps
module motion_bbox_tracker #(
  parameter int H_RES = 320,
  parameter int V_RES = 240,
  localparam int XW = $clog2(H_RES),
  localparam int YW = $clog2(V_RES),
  localparam int CW = $clog2(H_RES*V_RES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          frame_start,
  input  logic          pixel_valid,
  input  logic          diff_detected,
  input  logic [CW-1:0] motion_th,
  output logic          frame_done,
  output logic          result_valid,
  output logic [CW-1:0] diff_cnt,
  output logic [XW-1:0] x_min,
  output logic [XW-1:0] x_max,
  output logic [YW-1:0] y_min,
  output logic [YW-1:0] y_max,
  output logic          bbox_valid,
  output logic          motion_detected
);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  localparam logic [XW-1:0] X_LAST = XW'(H_RES-1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_RES-1);

  state_t        state_q, state_d;
  logic [XW-1:0] x_q, x_d, xmin_q, xmin_d, xmax_q, xmax_d;
  logic [YW-1:0] y_q, y_d, ymin_q, ymin_d, ymax_q, ymax_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          any_q, any_d;
  logic          accept, last_pix, hit;

  always_comb begin
    accept   = (state_q == ACTIVE) && pixel_valid && !frame_start;
    last_pix = accept && (x_q == X_LAST) && (y_q == Y_LAST);
    hit      = accept && diff_detected;
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    cnt_d    = cnt_q;
    any_d    = any_q;
    xmin_d   = xmin_q;
    xmax_d   = xmax_q;
    ymin_d   = ymin_q;
    ymax_d   = ymax_q;

    case (state_q)
      IDLE:    state_d = IDLE;
      ACTIVE:  if (last_pix) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // frame_start restarts from any state and wins over a coincident pixel
    if (frame_start) begin
      state_d = ACTIVE;
      x_d     = '0;
      y_d     = '0;
      cnt_d   = '0;
      any_d   = 1'b0;
      xmin_d  = X_LAST;
      xmax_d  = '0;
      ymin_d  = Y_LAST;
      ymax_d  = '0;
    end else begin
      if (accept) begin
        if (x_q == X_LAST) begin
          x_d = '0;
          y_d = y_q + YW'(1);
        end else begin
          x_d = x_q + XW'(1);
        end
      end
      if (hit) begin
        cnt_d = cnt_q + CW'(1);
        any_d = 1'b1;
        if (x_q < xmin_q) xmin_d = x_q;
        if (x_q > xmax_q) xmax_d = x_q;
        if (y_q < ymin_q) ymin_d = y_q;
        if (y_q > ymax_q) ymax_d = y_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      x_q             <= '0;
      y_q             <= '0;
      cnt_q           <= '0;
      any_q           <= 1'b0;
      xmin_q          <= '0;
      xmax_q          <= '0;
      ymin_q          <= '0;
      ymax_q          <= '0;
      frame_done      <= 1'b0;
      result_valid    <= 1'b0;
      diff_cnt        <= '0;
      x_min           <= '0;
      x_max           <= '0;
      y_min           <= '0;
      y_max           <= '0;
      bbox_valid      <= 1'b0;
      motion_detected <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      cnt_q        <= cnt_d;
      any_q        <= any_d;
      xmin_q       <= xmin_d;
      xmax_q       <= xmax_d;
      ymin_q       <= ymin_d;
      ymax_q       <= ymax_d;
      frame_done   <= last_pix;
      result_valid <= last_pix;
      // Publish uses the _d values so the last pixel is included
      if (last_pix) begin
        diff_cnt        <= cnt_d;
        bbox_valid      <= any_d;
        motion_detected <= (cnt_d > motion_th);
        x_min           <= any_d ? xmin_d : '0;
        x_max           <= any_d ? xmax_d : '0;
        y_min           <= any_d ? ymin_d : '0;
        y_max           <= any_d ? ymax_d : '0;
      end
    end
  end

endmodule

// File: tb/tb_motion_bbox_tracker.sv
// Bench for motion_bbox_tracker on a reduced 20x12 frame: directed vector table,
// randomized frames against a raster-scan reference model, and multi-cycle corner cases.
`timescale 1ns/1ps
module tb_motion_bbox_tracker;

  localparam int H    = 20;
  localparam int V    = 12;
  localparam int NPIX = H*V;
  localparam int XW   = $clog2(H);
  localparam int YW   = $clog2(V);
  localparam int CW   = $clog2(H*V);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          frame_start = 1'b0;
  logic          pixel_valid = 1'b0;
  logic          diff_detected = 1'b0;
  logic [CW-1:0] motion_th = '0;
  logic          frame_done, result_valid, bbox_valid, motion_detected;
  logic [CW-1:0] diff_cnt;
  logic [XW-1:0] x_min, x_max;
  logic [YW-1:0] y_min, y_max;

  motion_bbox_tracker #(.H_RES(H), .V_RES(V)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .pixel_valid(pixel_valid),
    .diff_detected(diff_detected), .motion_th(motion_th), .frame_done(frame_done),
    .result_valid(result_valid), .diff_cnt(diff_cnt), .x_min(x_min), .x_max(x_max),
    .y_min(y_min), .y_max(y_max), .bbox_valid(bbox_valid), .motion_detected(motion_detected)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt; int xmin; int xmax; int ymin; int ymax; int bbox; int md;
  } res_t;

  typedef struct {
    int   n;
    int   x0; int y0; int x1; int y1; int x2; int y2;
    int   th;
    bit   gaps;
    res_t exp;
  } vec_t;

  int   checks = 0;
  int   failures = 0;
  int   pulses = 0;
  bit   map [NPIX];
  vec_t vecs [5];

  always @(negedge clk) if (frame_done) pulses++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_res(input string tag, input res_t e);
    check({tag, " diff_cnt"},        longint'(diff_cnt),        e.cnt);
    check({tag, " x_min"},           longint'(x_min),           e.xmin);
    check({tag, " x_max"},           longint'(x_max),           e.xmax);
    check({tag, " y_min"},           longint'(y_min),           e.ymin);
    check({tag, " y_max"},           longint'(y_max),           e.ymax);
    check({tag, " bbox_valid"},      longint'(bbox_valid),      e.bbox);
    check({tag, " motion_detected"}, longint'(motion_detected), e.md);
  endtask

  task automatic check_zero(input string tag);
    res_t z;
    z = '{0, 0, 0, 0, 0, 0, 0};
    check({tag, " frame_done"},   longint'(frame_done),   0);
    check({tag, " result_valid"}, longint'(result_valid), 0);
    check_res(tag, z);
  endtask

  // Reference: scan the changed-pixel map in raster order
  function automatic res_t model(input int th);
    res_t r;
    r = '{0, H-1, 0, V-1, 0, 0, 0};
    for (int p = 0; p < NPIX; p++) begin
      if (map[p]) begin
        r.cnt++;
        r.bbox = 1;
        if (p % H < r.xmin) r.xmin = p % H;
        if (p % H > r.xmax) r.xmax = p % H;
        if (p / H < r.ymin) r.ymin = p / H;
        if (p / H > r.ymax) r.ymax = p / H;
      end
    end
    if (r.bbox == 0) begin
      r.xmin = 0; r.xmax = 0; r.ymin = 0; r.ymax = 0;
    end
    r.md = (r.cnt > th) ? 1 : 0;
    return r;
  endfunction

  task automatic clear_map();
    for (int p = 0; p < NPIX; p++) map[p] = 1'b0;
  endtask

  // One full frame from map[]; the frame_start cycle also carries a valid changed pixel
  // that must be discarded. Returns at the cycle after the last pixel (tail=1) or one later.
  task automatic run_frame(input int th, input bit gaps, input bit tail, input string tag);
    bit early;
    early = 1'b0;
    frame_start = 1'b1; pixel_valid = 1'b1; diff_detected = 1'b1;
    step();
    frame_start = 1'b0;
    for (int p = 0; p < NPIX; p++) begin
      if (gaps) begin
        for (int g = 0; g < 3 && $urandom_range(0, 2) == 0; g++) begin
          pixel_valid = 1'b0; diff_detected = 1'($urandom); motion_th = CW'($urandom);
          step();
          early |= frame_done;
        end
      end
      pixel_valid   = 1'b1;
      diff_detected = map[p];
      motion_th     = (p == NPIX-1) ? CW'(th) : CW'($urandom);
      step();
      if (p != NPIX-1) early |= frame_done;
    end
    pixel_valid = 1'b0; diff_detected = 1'b0;
    check({tag, " early_done"},   longint'(early),        0);
    check({tag, " frame_done"},   longint'(frame_done),   1);
    check({tag, " result_valid"}, longint'(result_valid), 1);
    if (!tail) begin
      step();
      check({tag, " done_low"},  longint'(frame_done),   0);
      check({tag, " valid_low"}, longint'(result_valid), 0);
    end
  endtask

  task automatic feed(input int n, input bit all_diff, output bit saw_done);
    saw_done = 1'b0;
    for (int i = 0; i < n; i++) begin
      pixel_valid = 1'b1;
      diff_detected = all_diff ? 1'b1 : 1'($urandom);
      step();
      saw_done |= frame_done;
    end
    pixel_valid = 1'b0; diff_detected = 1'b0;
  endtask

  initial begin
    bit   saw;
    int   p0, th, dens;
    res_t e;

    vecs[0] = '{0, -1, -1, -1, -1, -1, -1, 0, 1'b0, '{0, 0, 0, 0, 0, 0, 0}};
    vecs[1] = '{3, 3, 2, 15, 2, 7, 10, 2, 1'b0, '{3, 3, 15, 2, 10, 1, 1}};
    vecs[2] = '{3, 3, 2, 15, 2, 7, 10, 3, 1'b0, '{3, 3, 15, 2, 10, 1, 0}};
    vecs[3] = '{2, 0, 0, 19, 11, -1, -1, 0, 1'b1, '{2, 0, 19, 0, 11, 1, 1}};
    vecs[4] = '{1, 5, 7, -1, -1, -1, -1, 1, 1'b1, '{1, 5, 5, 7, 7, 1, 0}};

    // Reset and pixels without a frame_start
    reset = 1'b1;
    repeat (3) step();
    check_zero("reset");
    reset = 1'b0;
    feed(NPIX + 5, 1'b0, saw);
    check("idle_no_done", longint'(saw), 0);
    check("idle_cnt", longint'(diff_cnt), 0);

    foreach (vecs[i]) begin
      clear_map();
      if (vecs[i].n > 0) map[vecs[i].y0*H + vecs[i].x0] = 1'b1;
      if (vecs[i].n > 1) map[vecs[i].y1*H + vecs[i].x1] = 1'b1;
      if (vecs[i].n > 2) map[vecs[i].y2*H + vecs[i].x2] = 1'b1;
      run_frame(vecs[i].th, vecs[i].gaps, 1'b0, $sformatf("vec%0d", i));
      check_res($sformatf("vec%0d", i), vecs[i].exp);
    end

    for (int f = 0; f < 4; f++) begin
      dens = (f == 0) ? 2 : (f == 1) ? 30 : (f == 2) ? 100 : $urandom_range(0, 60);
      for (int p = 0; p < NPIX; p++) map[p] = ($urandom_range(0, 99) < dens);
      th = $urandom_range(0, NPIX);
      if (f == 1) th = model(0).cnt;
      run_frame(th, 1'($urandom), 1'b0, $sformatf("rand%0d", f));
      check_res($sformatf("rand%0d", f), model(th));
    end

    // Abort a partial frame, then a full frame with 7 changes
    p0 = pulses;
    frame_start = 1'b1; step(); frame_start = 1'b0;
    feed(100, 1'b1, saw);
    check("abort_no_done", longint'(saw), 0);
    clear_map();
    map[1*H+2] = 1; map[1*H+6] = 1; map[4*H+10] = 1; map[7*H+3] = 1;
    map[8*H+17] = 1; map[9*H+8] = 1; map[10*H+12] = 1;
    run_frame(6, 1'b1, 1'b0, "abort");
    e = '{7, 2, 17, 1, 10, 1, 1};
    check_res("abort", e);
    check("abort_pulses", longint'(pulses - p0), 1);

    // Back-to-back: second frame_start in the DONE cycle
    clear_map();
    map[3*H+4] = 1;
    run_frame(5, 1'b0, 1'b1, "b2b_a");
    e = '{1, 4, 4, 3, 3, 1, 0};
    check_res("b2b_a", e);
    for (int p = 0; p < NPIX; p++) map[p] = 1'b1;
    run_frame(0, 1'b0, 1'b0, "b2b_b");
    e = '{240, 0, 19, 0, 11, 1, 1};
    check_res("b2b_b", e);

    // Mid-frame reset loses the partial frame
    p0 = pulses;
    frame_start = 1'b1; step(); frame_start = 1'b0;
    feed(50, 1'b1, saw);
    reset = 1'b1; pixel_valid = 1'b1; diff_detected = 1'b1;
    step();
    reset = 1'b0; pixel_valid = 1'b0; diff_detected = 1'b0;
    check_zero("midreset");
    feed(NPIX, 1'b1, saw);
    check("midreset_no_done", longint'(saw), 0);
    check("midreset_pulses", longint'(pulses - p0), 0);
    check("midreset_cnt", longint'(diff_cnt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/motion_bbox_tracker.md
# motion_bbox_tracker

Per-frame motion accumulator downstream of the per-pixel difference detector. Consumes the qualified `diff_detected` stream in raster order and tracks pixel coordinates internally. It accumulates the changed-pixel count and the bounding box of changed pixels. At end of frame it publishes count, box and a thresholded motion flag, and emits the `frame_done` pulse that clears the per-frame difference counter.

## Interface
- `H_RES`, 320, active pixels per line
- `V_RES`, 240, active lines per frame
- Derived widths:
  - `XW` = $clog2(H_RES)
  - `YW` = $clog2(V_RES)
  - `CW` = $clog2(H_RES*V_RES)
  - With defaults these are 9 / 8 / 17.

Ports:
- `clk`  in  1  single clock; everything is on its rising edge
- `reset`  in  1  synchronous, active-high reset
- `frame_start`  in  1  one-cycle pulse that arms or restarts accumulation for a new frame
- `pixel_valid`  in  1  a pixel is presented this cycle
- `diff_detected`  in  1  the presented pixel differs from the previous frame; only meaningful while `pixel_valid` is high
- `motion_th`  in  CW  motion threshold, sampled in the last-pixel cycle
- `frame_done`  out  1  one-cycle pulse after the last pixel of a frame
- `result_valid`  out  1  one-cycle pulse, coincident with `frame_done`; marks an update of the result outputs
- `diff_cnt`  out  CW  changed-pixel count of the last completed frame
- `x_min`, `x_max`  out  XW  horizontal bounding-box limits, inclusive
- `y_min`, `y_max`  out  YW  vertical bounding-box limits, inclusive
- `bbox_valid`  out  1  the last completed frame had at least one changed pixel
- `motion_detected`  out  1  `diff_cnt` > `motion_th` for the last completed frame

## Operation
- States:
  - IDLE: ignore pixels and wait for `frame_start`.
  - ACTIVE: accumulate.
  - DONE: a one-cycle publish state.
- Transitions:
  - IDLE→ACTIVE on `frame_start`.
  - ACTIVE→DONE when the pixel at x=H_RES-1, y=V_RES-1 is accepted.
  - DONE→IDLE, or DONE→ACTIVE if `frame_start` is high in DONE.
- On entering ACTIVE:
  - x=0, y=0, cnt=0, any=0
  - xmin=H_RES-1, xmax=0, ymin=V_RES-1, ymax=0
- Pixel acceptance in ACTIVE (`pixel_valid`=1 and `frame_start`=0):
  - x increments; at H_RES-1 it wraps to 0 and y increments.
  - If `diff_detected`: cnt+1, any=1, and xmin/xmax/ymin/ymax take min/max against the current (x,y).
- `cnt` cannot overflow: maximum H_RES*V_RES fits in CW.
- `frame_start` in ACTIVE aborts the partial frame:
  - Accumulators are re-initialised.
  - Nothing is published and no `frame_done` is issued.
- `frame_start` with `pixel_valid` in the same cycle: `frame_start` wins and the pixel is discarded.
- `pixel_valid` in IDLE or DONE is ignored.
- Publish (registered at the edge leaving the last-pixel cycle; the last pixel is included):
  - `diff_cnt` = cnt
  - `bbox_valid` = any
  - `motion_detected` = (cnt > `motion_th`)
  - If any=1: box outputs = accumulated limits.
  - If any=0: all four box outputs = 0.
- Result outputs hold their values until the next publish.

## Timing
- Reset (synchronous):
  - state=IDLE
  - every output = 0, including both pulses and all box outputs
  - internal counters cleared
- Reset outranks all other inputs, including mid-frame; the partial frame is lost.
- `frame_start` sampled in cycle T: the first pixel can be accepted in cycle T+1.
- Last pixel accepted in cycle N:
  - `frame_done`, `result_valid` and the new result values are visible in cycle N+1 (latency 1).
  - The pulses are low again in N+2.
- `frame_done` is driven from a register with no combinational path from inputs, so it is safe to feed the difference counter's clear.
- Throughput: one pixel per cycle. Gaps (`pixel_valid`=0) stall x/y with no side effects.
- Back-to-back frames: `frame_start` may be asserted in the DONE cycle (N+1) with no lost cycle.

## Test plan
- **Reset values:** reset for 3 cycles → all outputs 0, state IDLE; pixels with `pixel_valid` before any `frame_start` → no `frame_done` ever.
- **Empty frame:** `frame_start`, then 76800 pixels all `diff_detected`=0, `motion_th`=0 → one `frame_done`/`result_valid` pulse one cycle after the last pixel; `diff_cnt`=0, `bbox_valid`=0, box=0, `motion_detected`=0.
- **Box and threshold:**
  - Stimulus: diffs at (10,5), (200,5), (50,180), `motion_th`=2.
  - Required result: `diff_cnt`=3, `x_min`=10, `x_max`=200, `y_min`=5, `y_max`=180, `motion_detected`=1.
  - Same frame with `motion_th`=3 → `motion_detected`=0.
- **Corners and stalls:**
  - Stimulus: diffs at (0,0) and (319,239), random `pixel_valid` gaps.
  - Required result: box = 0/319/0/239, `diff_cnt`=2, and `frame_done` exactly one cycle after the (319,239) pixel.
- **Abort:**
  - Stimulus: `frame_start` mid-frame after 1000 diff pixels, then a full frame with 7 diffs.
  - Required result: only one publish, with `diff_cnt`=7.
  - The same test covers a coincident `frame_start`+`pixel_valid`: that pixel is not counted.
- **Back-to-back and mid-frame reset:**
  - `frame_start` in the DONE cycle; second frame all diffs → `diff_cnt`=76800, box = 0/319/0/239.
  - `reset` at pixel 500 → outputs 0 and no publish.
